// File: rtl/veririsc_sequencer.sv
// rtl/veririsc_sequencer.sv - VeriRISC 8-phase control sequencer with stall, halt and single-step
module veririsc_sequencer #(
   parameter bit          STALL_EN = 1'b1,
   parameter int unsigned TIMEOUT  = 15,
   parameter int unsigned TO_W     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] opcode,
   input  logic       zero,
   input  logic       mem_rdy,
   input  logic       go,
   input  logic       step_mode,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       halt,
   output logic       ld_pc,
   output logic       data_e,
   output logic       ld_ac,
   output logic       wr,
   output logic [2:0] phase,
   output logic       halted,
   output logic       fault
);

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_HALTED = 2'd1;
   localparam logic [1:0] ST_FAULT  = 2'd2;

   // Last stall count value before the fault fires; unused when TIMEOUT is 0.
   localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

   logic [1:0]      state;
   logic [TO_W-1:0] stall_cnt;
   logic            mem_ok;
   logic            is_alu_ld;
   logic            stall_pt;
   logic            stalled;
   logic            to_hit;

   assign mem_ok    = !STALL_EN || mem_rdy;
   assign is_alu_ld = (opcode == OP_ADD) || (opcode == OP_AND) ||
                      (opcode == OP_XOR) || (opcode == OP_LDA);
   assign stall_pt  = (phase == 3'd3) ||
                      ((phase == 3'd7) && (is_alu_ld || (opcode == OP_STO)));
   assign stalled   = (state == ST_RUN) && !mem_ok && stall_pt;
   assign to_hit    = (TIMEOUT != 0) && (stall_cnt == TO_LAST);

   assign halted = (state == ST_HALTED);
   assign fault  = (state == ST_FAULT);

   // State, phase and stall counter: advance, stall, halt/step, restart and timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_RUN;
         phase     <= 3'd0;
         stall_cnt <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (stalled) begin
                  if (to_hit) begin
                     state     <= ST_FAULT;
                     stall_cnt <= '0;
                  end else begin
                     stall_cnt <= stall_cnt + TO_W'(1);
                  end
               end else begin
                  stall_cnt <= '0;
                  if ((phase == 3'd4) && (opcode == OP_HLT)) begin
                     state <= ST_HALTED;
                     phase <= 3'd0;
                  end else if ((phase == 3'd7) && step_mode) begin
                     state <= ST_HALTED;
                     phase <= 3'd0;
                  end else begin
                     phase <= phase + 3'd1;
                  end
               end
            end
            ST_HALTED: begin
               stall_cnt <= '0;
               if (go) begin
                  state <= ST_RUN;
                  phase <= 3'd0;
               end
            end
            ST_FAULT: begin
               stall_cnt <= '0;
            end
            default: begin
               // Unreachable encoding is treated as a fault so it can only be left by reset.
               state     <= ST_FAULT;
               stall_cnt <= '0;
            end
         endcase
      end
   end

   // Datapath strobe decode; everything is quiet outside RUN.
   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      halt   = 1'b0;
      ld_pc  = 1'b0;
      data_e = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      if (state == ST_RUN) begin
         case (phase)
            3'd0: sel = 1'b1;
            3'd1: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            3'd2, 3'd3: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            3'd4: begin
               inc_pc = 1'b1;
               halt   = (opcode == OP_HLT);
            end
            3'd5: rd = is_alu_ld;
            3'd6: begin
               rd     = is_alu_ld;
               inc_pc = (opcode == OP_SKZ) && zero;
               data_e = (opcode == OP_STO);
               ld_pc  = (opcode == OP_JMP);
            end
            default: begin
               rd     = is_alu_ld;
               // Gated by mem_ok so a stalled load writes the accumulator only once.
               ld_ac  = is_alu_ld && mem_ok;
               data_e = (opcode == OP_STO);
               wr     = (opcode == OP_STO);
               ld_pc  = (opcode == OP_JMP);
            end
         endcase
      end
   end

endmodule

// File: tb/tb_veririsc_sequencer.sv
// tb/tb_veririsc_sequencer.sv - directed self-checking bench for veririsc_sequencer
module tb_veririsc_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] opcode;
   logic       zero;
   logic       mem_rdy;
   logic       go;
   logic       step_mode;
   logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
   logic [2:0] phase;
   logic       halted;
   logic       fault;
   logic [8:0] strb;

   int n_assert = 0;
   int n_fail   = 0;

   // strobe order: sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr
   assign strb = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};

   logic [8:0] lda_tab [8];
   logic [8:0] hlt_tab [5];

   veririsc_sequencer #(.STALL_EN(1'b1), .TIMEOUT(4), .TO_W(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_rdy(mem_rdy),
      .go(go), .step_mode(step_mode),
      .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .halt(halt),
      .ld_pc(ld_pc), .data_e(data_e), .ld_ac(ld_ac), .wr(wr),
      .phase(phase), .halted(halted), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic goto_phase(input logic [2:0] p);
      int n = 0;
      while (phase !== p && n < 20) begin
         tick();
         n++;
      end
      chk("goto_phase", {6'd0, phase}, {6'd0, p});
   endtask

   initial begin
      lda_tab[0] = 9'b100000000;
      lda_tab[1] = 9'b110000000;
      lda_tab[2] = 9'b111000000;
      lda_tab[3] = 9'b111000000;
      lda_tab[4] = 9'b000100000;
      lda_tab[5] = 9'b010000000;
      lda_tab[6] = 9'b010000000;
      lda_tab[7] = 9'b010000010;
      hlt_tab[0] = 9'b100000000;
      hlt_tab[1] = 9'b110000000;
      hlt_tab[2] = 9'b111000000;
      hlt_tab[3] = 9'b111000000;
      hlt_tab[4] = 9'b000110000;

      rst = 1'b1; opcode = 3'd5; zero = 1'b0; mem_rdy = 1'b1; go = 1'b0; step_mode = 1'b0;
      tick(); tick();
      chk("rst_phase", {6'd0, phase}, 9'd0);
      chk("rst_strb", strb, 9'b100000000);
      chk("rst_halted", {8'd0, halted}, 9'd0);
      chk("rst_fault", {8'd0, fault}, 9'd0);
      rst = 1'b0;
      #1;

      // LDA, no stalls
      for (int p = 0; p < 8; p++) begin
         chk("lda_phase", {6'd0, phase}, 9'(p));
         chk("lda_strb", strb, lda_tab[p]);
         tick();
      end
      chk("lda_wrap", {6'd0, phase}, 9'd0);

      // HLT then restart
      opcode = 3'd0;
      #1;
      for (int p = 0; p < 5; p++) begin
         chk("hlt_strb", strb, hlt_tab[p]);
         tick();
      end
      chk("hlt_halted", {8'd0, halted}, 9'd1);
      chk("hlt_strb_off", strb, 9'd0);
      chk("hlt_phase", {6'd0, phase}, 9'd0);
      opcode = 3'd2;
      tick();
      chk("hlt_hold", {8'd0, halted}, 9'd1);
      go = 1'b1;
      #1;
      chk("go_same_cycle", {8'd0, halted}, 9'd1);
      tick();
      go = 1'b0;
      #1;
      chk("go_halted", {8'd0, halted}, 9'd0);
      chk("go_strb", strb, 9'b100000000);
      chk("go_phase", {6'd0, phase}, 9'd0);

      // ADD with a 3-cycle stall at phase 7, released on the TIMEOUT-1 count
      for (int p = 0; p < 7; p++) begin
         chk("add_strb", strb, lda_tab[p]);
         tick();
      end
      mem_rdy = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("add_stall_phase", {6'd0, phase}, 9'd7);
         chk("add_stall_strb", strb, 9'b010000000);
         tick();
      end
      mem_rdy = 1'b1;
      #1;
      chk("add_release_strb", strb, 9'b010000010);
      tick();
      chk("add_next_phase", {6'd0, phase}, 9'd0);
      chk("add_no_fault", {8'd0, fault}, 9'd0);

      // SKZ taken / not taken, JMP
      opcode = 3'd1; zero = 1'b1;
      goto_phase(3'd6);
      chk("skz_z1_strb", strb, 9'b000100000);
      tick();
      chk("skz_p7_strb", strb, 9'd0);
      tick();
      zero = 1'b0;
      goto_phase(3'd6);
      chk("skz_z0_strb", strb, 9'd0);
      goto_phase(3'd0);
      opcode = 3'd7;
      goto_phase(3'd6);
      chk("jmp_p6_strb", strb, 9'b000001000);
      tick();
      chk("jmp_p7_strb", strb, 9'b000001000);
      tick();

      // Single-step STO
      opcode = 3'd6; step_mode = 1'b1;
      goto_phase(3'd5);
      chk("sto_p5_strb", strb, 9'd0);
      tick();
      chk("sto_p6_strb", strb, 9'b000000100);
      tick();
      chk("sto_p7_strb", strb, 9'b000000101);
      tick();
      chk("step_halted", {8'd0, halted}, 9'd1);
      chk("step_phase", {6'd0, phase}, 9'd0);
      for (int r = 0; r < 2; r++) begin
         go = 1'b1;
         tick();
         go = 1'b0;
         for (int p = 0; p < 8; p++) begin
            chk("step_run", {5'd0, halted, phase}, 9'(p));
            tick();
         end
         chk("step_rehalt", {8'd0, halted}, 9'd1);
      end
      step_mode = 1'b0; opcode = 3'd5;
      go = 1'b1;
      tick();
      go = 1'b0;

      // Timeout at phase 3
      goto_phase(3'd3);
      mem_rdy = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("to_stall", {fault, strb[8:6], 2'd0, phase}, 9'b011100011);
         tick();
      end
      chk("to_fault", {8'd0, fault}, 9'd1);
      chk("to_strb", strb, 9'd0);
      chk("to_halted", {8'd0, halted}, 9'd0);
      go = 1'b1;
      tick();
      go = 1'b0;
      #1;
      chk("fault_ignores_go", {8'd0, fault}, 9'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_fault", {8'd0, fault}, 9'd0);
      chk("async_rst_phase", {6'd0, phase}, 9'd0);
      chk("async_rst_strb", strb, 9'b100000000);
      mem_rdy = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_phase", {6'd0, phase}, 9'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
